// File: rtl/zx81_tape_player_if.sv
// Download and tape-buffer port bundle for zx81_tape_player.
// The master side is the player, which owns the buffer port.
interface zx81_tape_player_if;
    logic        dl_active;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic [15:0] buf_addr;
    logic        buf_we;
    logic [7:0]  buf_din;
    logic [7:0]  buf_dout;

    modport master (
        input  dl_active,
        input  dl_wr,
        input  dl_addr,
        input  dl_data,
        input  buf_dout,
        output buf_addr,
        output buf_we,
        output buf_din
    );

    modport slave (
        output dl_active,
        output dl_wr,
        output dl_addr,
        output dl_data,
        output buf_dout,
        input  buf_addr,
        input  buf_we,
        input  buf_din
    );
endinterface

// File: rtl/zx81_tape_player.sv
// ZX81 .P image playback: forwards downloads into the tape buffer, then replays
// the buffer as the cassette pulse train (9 pulses for a 1, 4 for a 0, MSB first).
module zx81_tape_player #(
    parameter int unsigned CLK_KHZ   = 6500,
    parameter int unsigned PULSE_US  = 150,
    parameter int unsigned GAP_US    = 1300,
    parameter int unsigned LEADER_MS = 500
) (
    input  logic                      CLK_VIDEO,
    input  logic                      reset,
    zx81_tape_player_if.master        bus,
    input  logic                      play,
    output logic                      tape_out,
    output logic                      tape_ready,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned T_PULSE = CLK_KHZ * PULSE_US / 1000;
    localparam int unsigned T_GAP   = CLK_KHZ * GAP_US / 1000;
    localparam int unsigned T_LEAD  = CLK_KHZ * LEADER_MS;

    // Counter holds "cycles remaining minus one", so a load of T lasts exactly T cycles.
    localparam logic [23:0] LD_PULSE = 24'(T_PULSE - 1);
    localparam logic [23:0] LD_GAP   = 24'(T_GAP - 1);
    localparam logic [23:0] LD_LEAD  = 24'(T_LEAD - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLeader,
        StFetch,
        StLatch,
        StBit,
        StHi,
        StLo,
        StGap,
        StDone
    } state_e;

    state_e      r_state, w_state_d;
    logic [23:0] r_cnt, w_cnt_d;
    logic [16:0] r_len, w_len_d;
    logic [15:0] r_ptr, w_ptr_d;
    logic [7:0]  r_shreg, w_shreg_d;
    logic [2:0]  r_bitcnt, w_bitcnt_d;
    logic [3:0]  r_npulse, w_npulse_d;
    logic        r_play_q;
    logic        r_dl_q;

    logic        w_dl_rise;
    logic        w_play_rise;
    logic        w_cnt_zero;
    logic        w_last_byte;
    logic [16:0] w_wr_end;
    logic [16:0] w_len_base;

    assign w_dl_rise   = bus.dl_active & ~r_dl_q;
    assign w_play_rise = play & ~r_play_q;
    assign w_cnt_zero  = (r_cnt == 24'd0);
    assign w_last_byte = (({1'b0, r_ptr} + 17'd1) == r_len);
    assign w_wr_end    = {1'b0, bus.dl_addr} + 17'd1;

    assign bus.buf_addr = bus.dl_active ? bus.dl_addr : r_ptr;
    assign bus.buf_we   = bus.dl_active & bus.dl_wr;
    assign bus.buf_din  = bus.dl_data;

    assign tape_out   = (r_state == StHi);
    assign busy       = (r_state != StIdle);
    assign done       = (r_state == StDone);
    assign tape_ready = (r_len != 17'd0) & ~bus.dl_active;

    always_comb begin
        w_len_base = w_dl_rise ? 17'd0 : r_len;
        w_len_d    = w_len_base;
        if (bus.dl_active && bus.dl_wr && (w_wr_end > w_len_base)) begin
            w_len_d = w_wr_end;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_ptr_d    = r_ptr;
        w_shreg_d  = r_shreg;
        w_bitcnt_d = r_bitcnt;
        w_npulse_d = r_npulse;

        unique case (r_state)
            StIdle: begin
                w_ptr_d = 16'd0;
                if (w_play_rise && tape_ready) begin
                    w_cnt_d   = LD_LEAD;
                    w_state_d = StLeader;
                end
            end
            StLeader: begin
                if (w_cnt_zero) w_state_d = StFetch;
                else            w_cnt_d   = r_cnt - 24'd1;
            end
            StFetch: w_state_d = StLatch;
            StLatch: begin
                w_shreg_d  = bus.buf_dout;
                w_bitcnt_d = 3'd7;
                w_state_d  = StBit;
            end
            StBit: begin
                w_npulse_d = r_shreg[7] ? 4'd9 : 4'd4;
                w_cnt_d    = LD_PULSE;
                w_state_d  = StHi;
            end
            StHi: begin
                if (w_cnt_zero) begin
                    w_cnt_d   = LD_PULSE;
                    w_state_d = StLo;
                end else begin
                    w_cnt_d = r_cnt - 24'd1;
                end
            end
            StLo: begin
                if (w_cnt_zero) begin
                    w_npulse_d = r_npulse - 4'd1;
                    if (r_npulse != 4'd1) begin
                        w_cnt_d   = LD_PULSE;
                        w_state_d = StHi;
                    end else begin
                        w_cnt_d   = LD_GAP;
                        w_state_d = StGap;
                    end
                end else begin
                    w_cnt_d = r_cnt - 24'd1;
                end
            end
            StGap: begin
                if (w_cnt_zero) begin
                    if (r_bitcnt != 3'd0) begin
                        w_bitcnt_d = r_bitcnt - 3'd1;
                        w_shreg_d  = {r_shreg[6:0], 1'b0};
                        w_state_d  = StBit;
                    end else if (w_last_byte) begin
                        w_state_d = StDone;
                    end else begin
                        w_ptr_d   = r_ptr + 16'd1;
                        w_state_d = StFetch;
                    end
                end else begin
                    w_cnt_d = r_cnt - 24'd1;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Aborts rewind without a done strobe; a new download outranks everything.
        if ((r_state != StIdle && !play) || w_dl_rise) begin
            w_state_d = StIdle;
            w_ptr_d   = 16'd0;
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= 24'd0;
            r_len    <= 17'd0;
            r_ptr    <= 16'd0;
            r_shreg  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_npulse <= 4'd0;
            r_play_q <= 1'b0;
            r_dl_q   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_len    <= w_len_d;
            r_ptr    <= w_ptr_d;
            r_shreg  <= w_shreg_d;
            r_bitcnt <= w_bitcnt_d;
            r_npulse <= w_npulse_d;
            r_play_q <= play;
            r_dl_q   <= bus.dl_active;
        end
    end
endmodule

// File: tb/tb_zx81_tape_player.sv
// Randomized self-checking bench for zx81_tape_player against a timing model
// built from the pulse/gap/leader rules.
module tb_zx81_tape_player;
    localparam int unsigned CLK_KHZ   = 1000;
    localparam int unsigned PULSE_US  = 10;
    localparam int unsigned GAP_US    = 20;
    localparam int unsigned LEADER_MS = 1;
    localparam int P = CLK_KHZ * PULSE_US / 1000;
    localparam int G = CLK_KHZ * GAP_US / 1000;
    localparam int L = CLK_KHZ * LEADER_MS;

    logic CLK_VIDEO = 1'b0;
    logic reset;
    logic play;
    logic tape_out;
    logic tape_ready;
    logic busy;
    logic done;

    zx81_tape_player_if bus ();

    zx81_tape_player #(
        .CLK_KHZ  (CLK_KHZ),
        .PULSE_US (PULSE_US),
        .GAP_US   (GAP_US),
        .LEADER_MS(LEADER_MS)
    ) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .bus       (bus),
        .play      (play),
        .tape_out  (tape_out),
        .tape_ready(tape_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    logic [7:0] mem [0:65535];
    always @(posedge CLK_VIDEO) begin
        if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_din;
        bus.buf_dout <= mem[bus.buf_addr];
    end

    int cyc = 0;
    always @(posedge CLK_VIDEO) cyc <= cyc + 1;

    int   rises[$];
    int   falls[$];
    int   dones[$];
    logic mon_en = 1'b0;
    logic mon_prev = 1'b0;
    always @(negedge CLK_VIDEO) begin
        if (mon_en) begin
            if (tape_out && !mon_prev) rises.push_back(cyc);
            if (!tape_out && mon_prev) falls.push_back(cyc);
            if (done) dones.push_back(cyc);
        end
        mon_prev <= tape_out;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] img[$];

    task automatic tick();
        @(negedge CLK_VIDEO);
        #1;
    endtask

    task automatic start_monitor();
        rises.delete();
        falls.delete();
        dones.delete();
        mon_en = 1'b1;
    endtask

    // Writes img into the buffer in shuffled address order.
    task automatic load_image();
        int order[$];
        int j;
        int tmp;
        foreach (img[i]) order.push_back(i);
        for (int i = order.size() - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        bus.dl_active = 1'b1;
        tick();
        foreach (order[i]) begin
            bus.dl_wr   = 1'b1;
            bus.dl_addr = 16'(order[i]);
            bus.dl_data = img[order[i]];
            tick();
        end
        bus.dl_wr = 1'b0;
        tick();
        bus.dl_active = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        play = 1'b0;
        bus.dl_active = 1'b0;
        bus.dl_wr = 1'b0;
        bus.dl_addr = 16'd0;
        bus.dl_data = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({busy, done, tape_out, tape_ready, bus.buf_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {busy, done, tape_out, tape_ready, bus.buf_we});
        end
        n_checks++;
        if (bus.buf_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_buf_addr: got %h want 0000", bus.buf_addr);
        end
    endtask

    task automatic test_download();
        bus.dl_active = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.dl_wr = 1'b1;
            bus.dl_addr = 16'(i);
            bus.dl_data = 8'(i);
            #1;
            n_checks++;
            if ({bus.buf_we, bus.buf_addr, bus.buf_din} !== {1'b1, 16'(i), 8'(i)}) begin
                n_fail++;
                $display("FAIL dl_mux_%0d: got we=%b addr=%h din=%h want 1/%h/%h", i,
                         bus.buf_we, bus.buf_addr, bus.buf_din, 16'(i), 8'(i));
            end
            tick();
        end
        bus.dl_wr = 1'b0;
        #1;
        n_checks++;
        if (bus.buf_we !== 1'b0 || tape_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dl_idle: got we=%b ready=%b want 0/0", bus.buf_we, tape_ready);
        end
        tick();
        bus.dl_active = 1'b0;
        #1;
        n_checks++;
        if (tape_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dl_ready: got %b want 1", tape_ready);
        end
        n_checks++;
        if (dut.r_len !== 17'd3) begin
            n_fail++;
            $display("FAIL dl_len: got %0d want 3", dut.r_len);
        end
        tick();
    endtask

    task automatic test_len_max();
        bus.dl_active = 1'b1;
        tick();
        bus.dl_wr = 1'b1;
        bus.dl_addr = 16'hFFFF;
        bus.dl_data = 8'h11;
        tick();
        bus.dl_addr = 16'h0005;
        tick();
        bus.dl_wr = 1'b0;
        tick();
        n_checks++;
        if (dut.r_len !== 17'h10000) begin
            n_fail++;
            $display("FAIL len_max: got %h want 10000", dut.r_len);
        end
        bus.dl_active = 1'b0;
        #1;
        n_checks++;
        if (tape_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len_max_ready: got %b want 1", tape_ready);
        end
        tick();
    endtask

    // Plays img from a fresh play edge and checks the full pulse train timing.
    task automatic test_playback(input string name);
        int t;
        int t_end;
        int start;
        int exp_done;
        int n;
        int cnt;
        int budget;
        int exp_rise[$];
        int exp_bits[$];
        int obs_bits[$];
        logic [7:0] b;
        play = 1'b0;
        tick();
        start_monitor();
        play = 1'b1;
        start = cyc;
        t = start + L + 4;
        t_end = t;
        foreach (img[i]) begin
            b = img[i];
            for (int j = 7; j >= 0; j--) begin
                n = b[j] ? 9 : 4;
                exp_bits.push_back(n);
                for (int k = 0; k < n; k++) exp_rise.push_back(t + 2 * P * k);
                t_end = t + 2 * P * n + G;
                t = (j != 0) ? t_end + 1 : t_end + 3;
            end
        end
        exp_done = t_end;
        budget = exp_done - start + 100;
        for (int c = 0; c < budget && dones.size() == 0; c++) tick();
        repeat (3) tick();
        mon_en = 1'b0;

        n_checks++;
        if (dones.size() != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d want 1", name, dones.size());
        end else begin
            n_checks++;
            if (dones[0] != exp_done) begin
                n_fail++;
                $display("FAIL %s_done_time: got %0d want %0d", name,
                         dones[0] - start, exp_done - start);
            end
        end
        n_checks++;
        if (rises.size() != exp_rise.size() || falls.size() != exp_rise.size()) begin
            n_fail++;
            $display("FAIL %s_pulse_count: got rises=%0d falls=%0d want %0d", name,
                     rises.size(), falls.size(), exp_rise.size());
        end else begin
            foreach (exp_rise[k]) begin
                n_checks++;
                if (rises[k] != exp_rise[k] || falls[k] != exp_rise[k] + P) begin
                    n_fail++;
                    $display("FAIL %s_pulse_%0d: got rise=%0d fall=%0d want %0d/%0d", name, k,
                             rises[k] - start, falls[k] - start, exp_rise[k] - start,
                             exp_rise[k] + P - start);
                end
            end
        end
        cnt = 0;
        foreach (rises[k]) begin
            if (k > 0 && rises[k] - rises[k-1] != 2 * P) begin
                obs_bits.push_back(cnt);
                cnt = 0;
            end
            cnt++;
        end
        if (cnt > 0) obs_bits.push_back(cnt);
        n_checks++;
        if (obs_bits != exp_bits) begin
            n_fail++;
            $display("FAIL %s_bit_groups: got %0d groups (first %0d) want %0d (first %0d)",
                     name, obs_bits.size(), (obs_bits.size() > 0) ? obs_bits[0] : -1,
                     exp_bits.size(), exp_bits[0]);
        end
        n_checks++;
        if (busy !== 1'b0 || tape_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_idle: got busy=%b tape=%b want 0/0", name, busy, tape_out);
        end
    endtask

    task automatic test_single_byte();
        img = {8'hA5};
        load_image();
        test_playback("a5");
    endtask

    task automatic test_no_retrigger();
        logic bad = 1'b0;
        repeat (300) begin
            tick();
            if (busy) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL no_retrigger: got busy seen=%b want 0", bad);
        end
        test_playback("replay");
    endtask

    task automatic test_random_images();
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(4, 2);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            load_image();
            n_checks++;
            if (dut.r_len !== 17'(n)) begin
                n_fail++;
                $display("FAIL rand%0d_len: got %0d want %0d", r, dut.r_len, n);
            end
            test_playback($sformatf("rand%0d", r));
        end
    endtask

    task automatic test_abort_play();
        int n0;
        img = {8'($urandom), 8'($urandom)};
        load_image();
        n0 = img[0][7] ? 9 : 4;
        play = 1'b0;
        tick();
        start_monitor();
        play = 1'b1;
        for (int c = 0; c < L + 500 && rises.size() <= n0; c++) tick();
        n_checks++;
        if (rises.size() != n0 + 1 || tape_out !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_bit2: got rises=%0d tape=%b want %0d/1",
                     rises.size(), tape_out, n0 + 1);
        end
        play = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || tape_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_play_idle: got busy=%b tape=%b want 0/0", busy, tape_out);
        end
        repeat (300) tick();
        mon_en = 1'b0;
        n_checks++;
        if (dones.size() != 0) begin
            n_fail++;
            $display("FAIL abort_play_no_done: got %0d want 0", dones.size());
        end
        test_playback("restart");
    endtask

    task automatic test_abort_dl_and_empty();
        logic bad = 1'b0;
        img = {8'($urandom), 8'($urandom)};
        load_image();
        play = 1'b0;
        tick();
        play = 1'b1;
        repeat (L + 60) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_dl_playing: got busy=%b want 1", busy);
        end
        bus.dl_active = 1'b1;
        bus.dl_wr = 1'b0;
        bus.dl_addr = 16'($urandom);
        bus.dl_data = 8'($urandom);
        #1;
        n_checks++;
        if ({bus.buf_we, bus.buf_addr, bus.buf_din, tape_ready} !==
            {1'b0, bus.dl_addr, bus.dl_data, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_dl_mux: got we=%b addr=%h din=%h ready=%b want 0/%h/%h/0",
                     bus.buf_we, bus.buf_addr, bus.buf_din, tape_ready, bus.dl_addr, bus.dl_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || tape_out !== 1'b0 || dut.r_len !== 17'd0) begin
            n_fail++;
            $display("FAIL abort_dl_idle: got busy=%b tape=%b len=%0d want 0/0/0",
                     busy, tape_out, dut.r_len);
        end
        tick();
        bus.dl_active = 1'b0;
        tick();
        play = 1'b0;
        tick();
        play = 1'b1;
        repeat (50) begin
            tick();
            if (busy) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0 || tape_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_play: got busy seen=%b ready=%b want 0/0", bad, tape_ready);
        end
        play = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_gap();
        int n0;
        int target;
        img = {8'($urandom)};
        load_image();
        n0 = img[0][7] ? 9 : 4;
        play = 1'b0;
        tick();
        play = 1'b1;
        target = cyc + L + 4 + 2 * P * n0 + 5;
        while (cyc < target) tick();
        n_checks++;
        if (busy !== 1'b1 || tape_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_gap_state: got busy=%b tape=%b want 1/0", busy, tape_out);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({busy, done, tape_out, tape_ready, bus.buf_we} !== 5'b0 || bus.buf_addr !== 16'd0)
        begin
            n_fail++;
            $display("FAIL reset_in_gap_out: got %b addr=%h want 00000 addr=0000",
                     {busy, done, tape_out, tape_ready, bus.buf_we}, bus.buf_addr);
        end
        reset = 1'b0;
        play = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_download();
        test_len_max();
        test_single_byte();
        test_no_retrigger();
        test_random_images();
        test_abort_play();
        test_abort_dl_and_empty();
        test_reset_in_gap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/zx81_tape_player.md
# zx81_tape_player

Playback sequencer for a ZX81 `.P` tape image held in the core's tape buffer BRAM. It owns the buffer's single port. During an HPS download it forwards ioctl writes into the buffer and records the image length. When Play is switched on, it reads the image back byte by byte and emits the ZX81 cassette pulse train on `tape_out`, which the ZX81 core samples as its tape input. It sits beside the ZX81 core in the emu top level, driven from the OSD Play option, and feeds `tape_ready` to the user LED.

## Interface
Parameters:
- `CLK_KHZ`, 6500: CLK_VIDEO frequency in kHz.
- `PULSE_US`, 150: high time and low time of one tape pulse, in µs.
- `GAP_US`, 1300: silence after every bit, in µs.
- `LEADER_MS`, 500: silence before the first byte, in ms.

Ports (reset is synchronous, active-high; clock is CLK_VIDEO):
- `CLK_VIDEO`  in  1  system/video clock.
- `reset`  in  1  synchronous, active-high.
- `dl_active`  in  1  tape download in progress (ioctl_download qualified by index).
- `dl_wr`  in  1  download byte strobe.
- `dl_addr`  in  16  download byte address.
- `dl_data`  in  8  download byte.
- `play`  in  1  OSD Play switch (level).
- `buf_addr`  out  16  buffer address.
- `buf_we`  out  1  buffer write enable.
- `buf_din`  out  8  buffer write data.
- `buf_dout`  in  8  buffer read data, 1-cycle latency.
- `tape_out`  out  1  pulse train, 1 = pulse high.
- `tape_ready`  out  1  a non-empty image is loaded and no download is active.
- `busy`  out  1  playback in progress.
- `done`  out  1  one-cycle strobe when the last bit's gap ends.

## Operation
Derived constants:
- `T_PULSE = CLK_KHZ*PULSE_US/1000`
- `T_GAP = CLK_KHZ*GAP_US/1000`
- `T_LEAD = CLK_KHZ*LEADER_MS`
- All are computed at elaboration. There is one shared down-counter, 24 bits wide.

Arbitration:
- While `dl_active`=1: `buf_addr=dl_addr`, `buf_din=dl_data`, `buf_we=dl_wr`, combinationally (same cycle).
- Otherwise: `buf_we=0` and `buf_addr` = playback pointer `ptr`.

Length tracking:
- Rising edge of `dl_active`: `len` is cleared to 0.
- Each `dl_wr`: `len` is set to `max(len, dl_addr+1)`, using a 17-bit compare.
- The image length is 1..65536 bytes.

Start condition:
- Playback starts on a rising edge of `play` while `tape_ready`=1.
- A level held high does not restart playback after DONE.

State machine:
- **IDLE**: `ptr`=0, `tape_out`=0. On start, load `T_LEAD` and go to LEADER.
- **LEADER**: count down; at 0 go to FETCH.
- **FETCH**: drive `ptr`; next cycle go to LATCH.
- **LATCH**: `shreg` is set to `buf_dout`; `bitcnt` is set to 7. Go to BIT.
- **BIT**: `npulse` is set to 9 if `shreg[7]`=1, else 4 (MSB first). Load `T_PULSE` and go to HI.
- **HI**: `tape_out`=1; at 0 load `T_PULSE` and go to LO.
- **LO**: `tape_out`=0. At 0:
  - decrement `npulse`;
  - if `npulse` is still nonzero, go to HI;
  - otherwise load `T_GAP` and go to GAP.
- **GAP**: at 0:
  - if `bitcnt`≠0: decrement `bitcnt`, shift `shreg` left, go to BIT;
  - else if `ptr+1==len`: go to DONE;
  - else: increment `ptr`, go to FETCH.
- **DONE**: assert `done` for 1 cycle, then go to IDLE.

Aborts:
- `play`=0 in any non-IDLE state forces IDLE on the next cycle: rewind, `tape_out`=0, no `done`.
- `dl_active` rising does the same, and takes priority over everything.
- A simultaneous start edge and `dl_active` rising resolves to IDLE.

Outputs:
- `busy` = state≠IDLE.
- `tape_ready` = (`len`≠0) & ~`dl_active`.

## Timing
Reset values:
- State IDLE.
- `len`=0, `ptr`=0, `tape_out`=0, `busy`=0, `done`=0, `tape_ready`=0.
- Buffer outputs follow the arbitration mux (`buf_we`=0 when `dl_active`=0).

Cycle timing:
- First `tape_out` rising edge: the start edge + `T_LEAD` + 4 cycles.
- Each pulse period is exactly 2·`T_PULSE` cycles.
- A bit occupies `n`·2·`T_PULSE` + `T_GAP` + 1 cycles.
- Byte boundary overhead: 2 extra cycles (FETCH, LATCH).
- Counter reload happens in the cycle of the state transition, with no dead cycle inside HI/LO/GAP beyond those stated.

Reset mid-playback:
- Returns to IDLE within 1 cycle.
- `len` is lost; the image must be reloaded.

Boundary cases:
- `len`=65536: `ptr` reaches 0xFFFF, DONE follows; no wrap.
- Out-of-order download addresses still yield the correct maximum.

## Test plan
Use `CLK_KHZ`=1000, `PULSE_US`=10, `GAP_US`=20, `LEADER_MS`=1 for short counts.
- **Download**: write 0x00..0x02 at addresses 0..2 → `buf_we` mirrors `dl_wr` each cycle; `len`=3; `tape_ready`=1 after `dl_active` falls.
- **Single byte 0xA5**: play edge → `tape_out` pulse counts per bit 9,4,9,4,4,9,4,9; each pulse is 10 high / 10 low; gaps of 20; `done` fires once; `busy` falls.
- **Abort by play**: drop `play` during the second bit's HI → IDLE next cycle, `tape_out`=0, no `done`; re-raising `play` restarts from `ptr`=0 with the leader.
- **Abort by download**: raise `dl_active` mid-byte → IDLE, `len`=0, `tape_ready`=0, mux switches to the dl path the same cycle.
- **No retrigger**: keep `play` high after DONE → stays IDLE; a low→high edge replays the image.
- **Empty and reset**: play edge with `len`=0 → stays IDLE; `reset` pulsed during GAP → all outputs return to their reset values next cycle.
